qkv_stream_ctrl: RTL and testbench

//  Front-end producer for one backend PE: reads Q, K and V rows from on-chip SRAMs and streams them into the PE's
//  Q/K/V valid/ready inputs. For each query it sends Q once, then num_k K/V pairs, then waits for the PE's output

---
 rtl/qkv_stream_ctrl_pkg.sv | 11 +
 rtl/qkv_stream_ctrl_stream_buf.sv | 36 +++
 rtl/qkv_stream_ctrl.sv | 99 +++++++++
 tb/tb_qkv_stream_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/qkv_stream_ctrl_pkg.sv
// qkv_stream_ctrl_pkg: shared vector types, sizing constants and FSM states for the Q/K/V streamer
package qkv_stream_ctrl_pkg;
  localparam int MAX_SEQ = 64;
  localparam int MAX_EMBEDDING_DIM = 4;
  localparam int ELEM_W = 8;
  localparam int VEC_W = MAX_EMBEDDING_DIM * ELEM_W;
  typedef logic [VEC_W-1:0] q_vector_t;
  typedef logic [VEC_W-1:0] k_vector_t;
  typedef logic [VEC_W-1:0] v_vector_t;
  typedef enum logic [2:0] {IDLE, Q_PH, KV_PH, WAIT_O, DONE} state_t;
endpackage

// File: rtl/qkv_stream_ctrl_stream_buf.sv
// stream_buf: 2-entry valid/ready buffer fed by a 1-cycle SRAM read pipe, with read credit
module stream_buf #(
  parameter type T = logic [31:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic ren,
  input  T     rdata,
  output logic vld,
  input  logic rdy,
  output T     data,
  output logic credit
);
  T mem [2];
  logic inflight, wr_ptr, rd_ptr, pop;
  logic [1:0] cnt;
  // returning read data is presented directly when the buffer is empty
  assign vld = cnt != 2'd0 || inflight;
  assign data = cnt != 2'd0 ? mem[rd_ptr] : rdata;
  assign pop = vld && rdy;
  assign credit = {1'b0, cnt} + {2'b0, inflight} < 3'd2;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      inflight <= 1'b0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt <= 2'd0;
    end else begin
      inflight <= ren;
      if (inflight) wr_ptr <= ~wr_ptr;
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, inflight} - {1'b0, pop};
    end
  always_ff @(posedge clk)
    if (inflight) mem[wr_ptr] <= rdata;
endmodule

// File: rtl/qkv_stream_ctrl.sv
// qkv_stream_ctrl: reads Q/K/V rows from SRAM and streams Q then num_k K/V pairs per query into a PE
module qkv_stream_ctrl import qkv_stream_ctrl_pkg::*; #(
  parameter int MAX_SEQ = qkv_stream_ctrl_pkg::MAX_SEQ,
  parameter int ADDR_W = $clog2(MAX_SEQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   num_q,
  input  logic [ADDR_W:0]   num_k,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              q_ren,
  output logic              k_ren,
  output logic              v_ren,
  output logic [ADDR_W-1:0] q_addr,
  output logic [ADDR_W-1:0] k_addr,
  output logic [ADDR_W-1:0] v_addr,
  input  q_vector_t         q_rdata,
  input  k_vector_t         k_rdata,
  input  v_vector_t         v_rdata,
  output logic              Q_vld_out,
  output logic              K_vld_out,
  output logic              V_vld_out,
  input  logic              Q_rdy_in,
  input  logic              K_rdy_in,
  input  logic              V_rdy_in,
  output q_vector_t         q_vector,
  output k_vector_t         k_vector,
  output v_vector_t         v_vector,
  input  logic              o_fire
);
  localparam logic [ADDR_W:0] MAX_N = (ADDR_W+1)'(MAX_SEQ);
  state_t state, state_n;
  logic [ADDR_W:0] nq, nk, q_idx, k_iss, k_cnt, v_cnt;
  logic q_iss, q_credit, k_credit, v_credit, q_fire, k_fire, v_fire, kv_go, last_q;
  stream_buf #(.T(q_vector_t)) u_q (.clk(clk), .rst(rst), .ren(q_ren), .rdata(q_rdata), .vld(Q_vld_out),
    .rdy(Q_rdy_in), .data(q_vector), .credit(q_credit));
  stream_buf #(.T(k_vector_t)) u_k (.clk(clk), .rst(rst), .ren(k_ren), .rdata(k_rdata), .vld(K_vld_out),
    .rdy(K_rdy_in), .data(k_vector), .credit(k_credit));
  stream_buf #(.T(v_vector_t)) u_v (.clk(clk), .rst(rst), .ren(v_ren), .rdata(v_rdata), .vld(V_vld_out),
    .rdy(V_rdy_in), .data(v_vector), .credit(v_credit));
  assign q_fire = Q_vld_out && Q_rdy_in;
  assign k_fire = K_vld_out && K_rdy_in;
  assign v_fire = V_vld_out && V_rdy_in;
  assign last_q = q_idx == nq - 1'b1;
  assign q_ren = state == Q_PH && !q_iss && q_credit;
  // K and V rows are fetched in lockstep so the two streams never drift more than the buffer depth
  assign kv_go = state == KV_PH && k_iss != nk && k_credit && v_credit;
  assign k_ren = kv_go;
  assign v_ren = kv_go;
  assign q_addr = q_idx[ADDR_W-1:0];
  assign k_addr = k_iss[ADDR_W-1:0];
  assign v_addr = k_iss[ADDR_W-1:0];
  assign busy = state == Q_PH || state == KV_PH || state == WAIT_O;
  assign done = state == DONE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = (num_q == '0 || num_k == '0) ? DONE : Q_PH;
      Q_PH:    if (q_fire) state_n = KV_PH;
      KV_PH:   if (k_cnt == nk && v_cnt == nk) state_n = WAIT_O;
      WAIT_O:  if (o_fire) state_n = last_q ? DONE : Q_PH;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      err <= 1'b0;
      nq <= '0;
      nk <= '0;
      q_idx <= '0;
      k_iss <= '0;
      k_cnt <= '0;
      v_cnt <= '0;
      q_iss <= 1'b0;
    end else begin
      state <= state_n;
      err <= err || (o_fire && state != WAIT_O);
      if (state == IDLE && start) begin
        nq <= num_q > MAX_N ? MAX_N : num_q;
        nk <= num_k > MAX_N ? MAX_N : num_k;
        q_idx <= '0;
      end
      if (q_ren) q_iss <= 1'b1;
      if (state == Q_PH && q_fire) begin
        q_iss <= 1'b0;
        k_iss <= '0;
        k_cnt <= '0;
        v_cnt <= '0;
      end
      if (kv_go) k_iss <= k_iss + 1'b1;
      if (k_fire) k_cnt <= k_cnt + 1'b1;
      if (v_fire) v_cnt <= v_cnt + 1'b1;
      if (state == WAIT_O && o_fire && !last_q) q_idx <= q_idx + 1'b1;
    end
endmodule

// File: tb/tb_qkv_stream_ctrl.sv
// tb_qkv_stream_ctrl: table-driven job checks plus reset and abort sequences for qkv_stream_ctrl
module tb_qkv_stream_ctrl;
  import qkv_stream_ctrl_pkg::*;
  localparam int AW = 6;
  localparam logic [31:0] QB = 32'h1000_0000;
  localparam logic [31:0] KB = 32'h2000_0000;
  localparam logic [31:0] VB = 32'h3000_0000;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, o_fire = 1'b0;
  logic [AW:0] num_q = '0, num_k = '0;
  logic busy, done, err, q_ren, k_ren, v_ren;
  logic [AW-1:0] q_addr, k_addr, v_addr;
  q_vector_t q_rdata = '0, q_vector;
  k_vector_t k_rdata = '0, k_vector;
  v_vector_t v_rdata = '0, v_vector;
  logic Q_vld_out, K_vld_out, V_vld_out;
  logic Q_rdy_in = 1'b1, K_rdy_in = 1'b1, V_rdy_in = 1'b1;
  int total = 0, bad = 0;
  qkv_stream_ctrl dut (.clk(clk), .rst(rst), .start(start), .num_q(num_q), .num_k(num_k), .busy(busy),
    .done(done), .err(err), .q_ren(q_ren), .k_ren(k_ren), .v_ren(v_ren), .q_addr(q_addr), .k_addr(k_addr),
    .v_addr(v_addr), .q_rdata(q_rdata), .k_rdata(k_rdata), .v_rdata(v_rdata), .Q_vld_out(Q_vld_out),
    .K_vld_out(K_vld_out), .V_vld_out(V_vld_out), .Q_rdy_in(Q_rdy_in), .K_rdy_in(K_rdy_in),
    .V_rdy_in(V_rdy_in), .q_vector(q_vector), .k_vector(k_vector), .v_vector(v_vector), .o_fire(o_fire));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (q_ren) q_rdata <= QB + 32'(q_addr);
    if (k_ren) k_rdata <= KB + 32'(k_addr);
    if (v_ren) v_rdata <= VB + 32'(v_addr);
  end
  int cyc = 0, done_cnt, ren_cnt, hold_bad, kv_bad, skew_max, qren_bad, err_drop, q_xf, of_cnt, kq, vq;
  int acc_cyc, done_cyc;
  q_vector_t q_log[$];
  k_vector_t k_log[$];
  v_vector_t v_log[$];
  int k_st[$], v_st[$], qa_log[$], ka_log[$];
  logic pqv = 0, pqr = 0, pkv = 0, pkr = 0, pvv = 0, pvr = 0, perr = 0;
  logic [31:0] pqd, pkd, pvd;
  initial forever begin
    int sk;
    @(negedge clk);
    cyc++;
    if (rst) begin
      {pqv, pkv, pvv, perr} = '0;
      continue;
    end
    if (pqv && !pqr && !(Q_vld_out && q_vector == pqd)) hold_bad++;
    if (pkv && !pkr && !(K_vld_out && k_vector == pkd)) hold_bad++;
    if (pvv && !pvr && !(V_vld_out && v_vector == pvd)) hold_bad++;
    {pqv, pqr, pqd} = {Q_vld_out, Q_rdy_in, q_vector};
    {pkv, pkr, pkd} = {K_vld_out, K_rdy_in, k_vector};
    {pvv, pvr, pvd} = {V_vld_out, V_rdy_in, v_vector};
    if (Q_vld_out && Q_rdy_in) begin q_log.push_back(q_vector); q_xf++; kq = 0; vq = 0; end
    if (K_vld_out && K_rdy_in) begin k_log.push_back(k_vector); k_st.push_back(cyc); kq++; end
    if (V_vld_out && V_rdy_in) begin v_log.push_back(v_vector); v_st.push_back(cyc); vq++; end
    sk = k_log.size() - v_log.size();
    if (sk < 0) sk = -sk;
    if (sk > skew_max) skew_max = sk;
    if (q_ren) begin qa_log.push_back(int'(q_addr)); if (q_xf != of_cnt) qren_bad++; end
    if (k_ren) ka_log.push_back(int'(k_addr));
    if (k_ren != v_ren || k_addr != v_addr) kv_bad++;
    ren_cnt += int'(q_ren) + int'(k_ren) + int'(v_ren);
    if (o_fire) of_cnt++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (start && !busy && !done && acc_cyc < 0) acc_cyc = cyc;
    if (perr && !err) err_drop++;
    perr = err;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask
  task automatic clear_logs();
    q_log.delete(); k_log.delete(); v_log.delete(); k_st.delete(); v_st.delete();
    qa_log.delete(); ka_log.delete();
    {done_cnt, ren_cnt, hold_bad, kv_bad, skew_max, qren_bad, err_drop, q_xf, of_cnt, kq, vq} = '0;
    acc_cyc = -1;
    done_cyc = -1;
  endtask
  task automatic reset_checks(input string tag);
    chk({tag, "_busy"}, busy, 0); chk({tag, "_done"}, done, 0); chk({tag, "_err"}, err, 0);
    chk({tag, "_q_ren"}, q_ren, 0); chk({tag, "_k_ren"}, k_ren, 0); chk({tag, "_v_ren"}, v_ren, 0);
    chk({tag, "_q_addr"}, q_addr, 0); chk({tag, "_k_addr"}, k_addr, 0); chk({tag, "_v_addr"}, v_addr, 0);
    chk({tag, "_Q_vld"}, Q_vld_out, 0); chk({tag, "_K_vld"}, K_vld_out, 0); chk({tag, "_V_vld"}, V_vld_out, 0);
  endtask
  typedef struct {
    int nq, nk, eq, ek;
    bit krand, inj, eerr;
  } rec_t;
  task automatic run_job(input rec_t r);
    int wc = -1, qd = 0, mism = 0, gaps = 0;
    bit injd = 0, ok = 0;
    clear_logs();
    num_q = r.nq[AW:0];
    num_k = r.nk[AW:0];
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      K_rdy_in = r.krand ? 1'($urandom_range(0, 1)) : 1'b1;
      o_fire = 1'b0;
      start = 1'b0;
      if (r.inj && !injd && k_log.size() >= 1) begin
        o_fire = 1'b1; start = 1'b1; num_q = 7'd3; injd = 1;
      end else if (q_log.size() > qd && kq == r.ek && vq == r.ek) begin
        if (wc < 0) wc = 2;
        else if (wc == 0) begin o_fire = 1'b1; qd++; wc = -1; end
        else wc--;
      end
      tick();
      if (done_cnt > 0) begin ok = 1; break; end
    end
    o_fire = 1'b0; start = 1'b0; K_rdy_in = 1'b1;
    chk("done_seen", ok, 1);
    repeat (3) tick();
    chk("q_xfers", q_log.size(), r.eq);
    chk("k_xfers", k_log.size(), r.eq * r.ek);
    chk("v_xfers", v_log.size(), r.eq * r.ek);
    chk("done_pulses", done_cnt, 1);
    chk("busy_end", busy, 0);
    chk("err_end", err, r.eerr);
    if (qa_log.size() != r.eq || ka_log.size() != r.eq * r.ek) mism++;
    foreach (q_log[i]) if (q_log[i] != QB + 32'(i)) mism++;
    foreach (qa_log[i]) if (qa_log[i] != i) mism++;
    if (r.ek > 0) begin
      foreach (k_log[n]) if (k_log[n] != KB + 32'(n % r.ek)) mism++;
      foreach (v_log[n]) if (v_log[n] != VB + 32'(n % r.ek)) mism++;
      foreach (ka_log[n]) if (ka_log[n] != n % r.ek) mism++;
    end
    chk("order", mism, 0);
    chk("hold", hold_bad + kv_bad, 0);
    chk("skew_le2", skew_max <= 2, 1);
    chk("q_before_ofire", qren_bad, 0);
    chk("err_drop", err_drop, 0);
    if (r.eq == 0) begin
      chk("no_ren", ren_cnt, 0);
      chk("done_lat", done_cyc - acc_cyc, 1);
    end
    if (!r.krand && r.ek > 0) begin
      foreach (k_st[n]) if (n % r.ek != 0 && k_st[n] - k_st[n-1] != 1) gaps++;
      foreach (v_st[n]) if (n % r.ek != 0 && v_st[n] - v_st[n-1] != 1) gaps++;
      chk("b2b", gaps, 0);
    end
  endtask
  rec_t tbl[8];
  initial begin
    rec_t post;
    tbl[0] = '{nq: 1,  nk: 4,   eq: 1,  ek: 4,  krand: 0, inj: 0, eerr: 0};
    tbl[1] = '{nq: 3,  nk: 2,   eq: 3,  ek: 2,  krand: 0, inj: 0, eerr: 0};
    tbl[2] = '{nq: 1,  nk: 8,   eq: 1,  ek: 8,  krand: 1, inj: 0, eerr: 0};
    tbl[3] = '{nq: 0,  nk: 5,   eq: 0,  ek: 0,  krand: 0, inj: 0, eerr: 0};
    tbl[4] = '{nq: 2,  nk: 0,   eq: 0,  ek: 0,  krand: 0, inj: 0, eerr: 0};
    tbl[5] = '{nq: 1,  nk: 100, eq: 1,  ek: 64, krand: 0, inj: 0, eerr: 0};
    tbl[6] = '{nq: 70, nk: 1,   eq: 64, ek: 1,  krand: 0, inj: 0, eerr: 0};
    tbl[7] = '{nq: 1,  nk: 4,   eq: 1,  ek: 4,  krand: 0, inj: 1, eerr: 1};
    post   = '{nq: 1,  nk: 3,   eq: 1,  ek: 3,  krand: 0, inj: 0, eerr: 0};
    clear_logs();
    repeat (2) tick();
    reset_checks("rst");
    rst = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) run_job(tbl[i]);
    clear_logs();
    num_q = 7'd1;
    num_k = 7'd8;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 100 && !k_ren; c++) tick();
    chk("abort_k_ren", k_ren, 1);
    tick();
    rst = 1'b1;
    #1;
    reset_checks("abort");
    chk("abort_no_done", done_cnt, 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    run_job(post);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
